mem_port_arbiter: RTL and testbench

Shares one single-ported memory backend between the instruction-fetch port and the data-access port of the RISCV pipeline (checkpoint 2/3 memory system).
- Accepts level-held requests from both ports and serialises them onto the backend using a req/ack handshake.
- Returns read data with a one-cycle valid pulse.
- Drives the pipeline-wide stall while any request is unserved.
- Round-robin on contention; watchdog aborts hung accesses.

---
 rtl/mem_arb_pkg.sv | 26 ++
 rtl/rr_arb2.sv | 23 ++
 rtl/mem_port_arbiter.sv | 141 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the instruction/data memory port arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_t;

   typedef enum logic {
      INSTR = 1'b0,
      DATA  = 1'b1
   } grant_t;

   localparam int unsigned ADDR_W                 = 32;
   localparam int unsigned DATA_W                 = 32;
   localparam int unsigned BE_W                   = 4;
   localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 64;
   localparam logic [DATA_W-1:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

   // Watchdog counter width; never narrower than one bit.
   function automatic int unsigned timeout_cnt_w(input int unsigned cycles);
      return (cycles > 1) ? unsigned'($clog2(cycles)) : 1;
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin picker; the previous winner is stored by the caller.
module rr_arb2
   import mem_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic       grant,
   output logic       grant_valid
);

   // Bit 0 is the instruction port, bit 1 the data port.
   always_comb begin
      grant_valid = |req;
      grant       = 1'(INSTR);
      case (req)
         2'b01:   grant = 1'(INSTR);
         2'b10:   grant = 1'(DATA);
         2'b11:   grant = ~last_grant;
         default: grant = 1'(INSTR);
      endcase
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises instruction-fetch and data accesses onto one single-ported memory
// backend with round-robin arbitration, response pulses and an access watchdog.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned       TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
   parameter logic [DATA_W-1:0] ERR_DATA       = ERR_DATA_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ic_re,
   input  logic [ADDR_W-1:0] ic_addr,
   output logic [DATA_W-1:0] ic_dout,
   output logic              ic_valid,
   input  logic              dc_re,
   input  logic [BE_W-1:0]   dc_we,
   input  logic [ADDR_W-1:0] dc_addr,
   input  logic [DATA_W-1:0] dc_din,
   output logic [DATA_W-1:0] dc_dout,
   output logic              dc_valid,
   output logic              mem_req,
   output logic [BE_W-1:0]   mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_din,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_dout,
   output logic              stall,
   output logic              err
);

   localparam int unsigned    CNT_W    = timeout_cnt_w(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t            state;
   grant_t            last_grant;
   grant_t            cur_grant;
   logic [CNT_W-1:0]  cnt;

   logic              dc_any;
   logic              busy_i;
   logic              busy_d;
   logic              pend_i;
   logic              pend_d;
   logic              arb_grant;
   logic              arb_valid;
   logic              mem_is_read;
   logic              timed_out;
   logic [DATA_W-1:0] rsp_data;

   // A port is busy from its grant until its valid pulse; grants only happen in IDLE.
   assign dc_any = dc_re | (|dc_we);
   assign busy_i = (state != IDLE) && (cur_grant == INSTR);
   assign busy_d = (state != IDLE) && (cur_grant == DATA);
   assign pend_i = ic_re & ~busy_i;
   assign pend_d = dc_any & ~busy_d;

   assign mem_is_read = (mem_we == '0);
   assign timed_out   = ~mem_ack && (cnt == CNT_LAST);
   assign rsp_data    = mem_ack ? mem_dout : ERR_DATA;

   // Released in the valid cycle so the pipeline advances on that edge.
   assign stall = (ic_re & ~ic_valid) | (dc_any & ~dc_valid);

   rr_arb2 u_rr_arb2 (
      .req         ({pend_d, pend_i}),
      .last_grant  (last_grant),
      .grant       (arb_grant),
      .grant_valid (arb_valid)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         last_grant <= INSTR;
         cur_grant  <= INSTR;
         cnt        <= '0;
         mem_req    <= 1'b0;
         mem_we     <= '0;
         mem_addr   <= '0;
         mem_din    <= '0;
         ic_dout    <= '0;
         dc_dout    <= '0;
         ic_valid   <= 1'b0;
         dc_valid   <= 1'b0;
         err        <= 1'b0;
      end else begin
         ic_valid <= 1'b0;
         dc_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (arb_valid) begin
                  cur_grant  <= grant_t'(arb_grant);
                  last_grant <= grant_t'(arb_grant);
                  mem_req    <= 1'b1;
                  cnt        <= '0;
                  state      <= ISSUE;
                  if (grant_t'(arb_grant) == DATA) begin
                     // Non-zero byte enables make this a write even if dc_re is also set.
                     mem_addr <= {dc_addr[ADDR_W-1:2], 2'b00};
                     mem_we   <= dc_we;
                     mem_din  <= dc_din;
                  end else begin
                     mem_addr <= {ic_addr[ADDR_W-1:2], 2'b00};
                     mem_we   <= '0;
                     mem_din  <= '0;
                  end
               end
            end
            ISSUE: begin
               if (mem_ack || timed_out) begin
                  mem_req <= 1'b0;
                  state   <= RESP;
                  if (timed_out) begin
                     err <= 1'b1;
                  end
                  if (cur_grant == DATA) begin
                     dc_valid <= 1'b1;
                     if (mem_is_read) begin
                        dc_dout <= rsp_data;
                     end
                  end else begin
                     ic_valid <= 1'b1;
                     ic_dout  <= rsp_data;
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            RESP: begin
               cnt   <= '0;
               state <= IDLE;
            end
            default: begin
               mem_req <= 1'b0;
               state   <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic, checked every cycle
// against a transaction-timeline model of the arbiter.
module tb_mem_port_arbiter;

   localparam int unsigned TO  = 8;
   localparam logic [31:0] ERR = 32'hDEADBEEF;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ic_re = 1'b0;
   logic [31:0] ic_addr = '0;
   logic [31:0] ic_dout;
   logic        ic_valid;
   logic        dc_re = 1'b0;
   logic [3:0]  dc_we = '0;
   logic [31:0] dc_addr = '0;
   logic [31:0] dc_din = '0;
   logic [31:0] dc_dout;
   logic        dc_valid;
   logic        mem_req;
   logic [3:0]  mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_din;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_dout = '0;
   logic        stall;
   logic        err;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   mem_port_arbiter #(.TIMEOUT_CYCLES(TO), .ERR_DATA(ERR)) dut (
      .clk(clk), .rst(rst),
      .ic_re(ic_re), .ic_addr(ic_addr), .ic_dout(ic_dout), .ic_valid(ic_valid),
      .dc_re(dc_re), .dc_we(dc_we), .dc_addr(dc_addr), .dc_din(dc_din),
      .dc_dout(dc_dout), .dc_valid(dc_valid),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
      .mem_ack(mem_ack), .mem_dout(mem_dout),
      .stall(stall), .err(err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // Model: one transaction at a time, described by its grant cycle and end cycle.
   // mem_req spans (grant, end]; valid is at end+1; the arbiter is free again at end+2.
   bit          m_ok = 0, m_act = 0, m_end_known = 0, m_abort = 0;
   int          m_g = 0, m_end = 0;
   bit          m_port = 0;
   bit          m_last = 0;
   logic [31:0] m_addr = '0, m_din = '0;
   logic [3:0]  m_we = '0;
   logic [31:0] m_ic_dout = '0, m_dc_dout = '0;
   bit          m_err = 0;

   always @(negedge clk) begin : model
      bit          e_req, e_iv, e_dv, e_stall, free, ri, rd;
      logic [31:0] rdata;
      e_req = 0;
      if (m_ok) begin
         e_req   = m_act && (cyc > m_g) && (!m_end_known || cyc <= m_end);
         e_iv    = m_act && m_end_known && (cyc == m_end + 1) && !m_port;
         e_dv    = m_act && m_end_known && (cyc == m_end + 1) && m_port;
         e_stall = (ic_re && !e_iv) || ((dc_re || dc_we != 0) && !e_dv);
         chk("mem_req", 32'(mem_req), 32'(e_req));
         chk("ic_valid", 32'(ic_valid), 32'(e_iv));
         chk("dc_valid", 32'(dc_valid), 32'(e_dv));
         chk("ic_dout", ic_dout, m_ic_dout);
         chk("dc_dout", dc_dout, m_dc_dout);
         chk("err", 32'(err), 32'(m_err));
         chk("stall", 32'(stall), 32'(e_stall));
         if (e_req) begin
            chk("mem_addr", mem_addr, m_addr);
            chk("mem_we", 32'(mem_we), 32'(m_we));
            if (m_port) chk("mem_din", mem_din, m_din);
         end
      end
      if (rst) begin
         m_ok = 1; m_act = 0; m_last = 0;
         m_ic_dout = '0; m_dc_dout = '0; m_err = 0;
      end else if (m_ok) begin
         free = !m_act;
         if (e_req && !m_end_known) begin
            if (mem_ack) begin
               m_end_known = 1; m_end = cyc; m_abort = 0;
            end else if (cyc - m_g == int'(TO)) begin
               m_end_known = 1; m_end = cyc; m_abort = 1;
            end
            if (m_end_known) begin
               rdata = m_abort ? ERR : mem_dout;
               if (m_we == 0) begin
                  if (m_port) m_dc_dout = rdata;
                  else        m_ic_dout = rdata;
               end
               if (m_abort) m_err = 1;
            end
         end
         if (m_act && m_end_known && cyc == m_end + 1) m_act = 0;
         ri = ic_re;
         rd = dc_re || (dc_we != 0);
         if (free && (ri || rd)) begin
            m_port      = (ri && rd) ? !m_last : rd;
            m_last      = m_port;
            m_act       = 1;
            m_end_known = 0;
            m_g         = cyc;
            m_addr      = (m_port ? dc_addr : ic_addr) & 32'hFFFF_FFFC;
            m_we        = m_port ? dc_we : 4'h0;
            m_din       = dc_din;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1; ic_re = 0; dc_re = 0; dc_we = 0; mem_ack = 0;
      tick();
      tick();
      rst = 0;
   endtask

   // Random requesters and backend; requests are held until their valid pulse.
   task automatic rand_phase(input int n, input int ack_pct, input bit allow_rst);
      bit iv, dv;
      int kind;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         iv = ic_valid;
         dv = dc_valid;
         tick();
         if (rst) rst = 0;
         if (!ic_re || iv) begin
            ic_re   = ($urandom_range(0, 2) == 0);
            ic_addr = $urandom;
         end
         if (!(dc_re || dc_we != 0) || dv) begin
            dc_re = 0; dc_we = 0;
            if ($urandom_range(0, 2) == 0) begin
               kind    = $urandom_range(0, 2);
               dc_re   = (kind != 1);
               dc_we   = (kind == 0) ? 4'h0 : 4'($urandom_range(1, 15));
               dc_addr = $urandom;
               dc_din  = $urandom;
            end
         end
         mem_ack  = mem_req ? ($urandom_range(0, 99) < ack_pct) : ($urandom_range(0, 7) == 0);
         mem_dout = $urandom;
         if (allow_rst && $urandom_range(0, 299) == 0) begin
            rst = 1; ic_re = 0; dc_re = 0; dc_we = 0;
         end
      end
      rst = 0; ic_re = 0; dc_re = 0; dc_we = 0; mem_ack = 0;
      repeat (TO + 4) tick();
   endtask

   int stall_n, nd, ni, seq, kd, ki, nreq, nval, ng;
   bit dv_prev, iv_prev, seen;

   initial begin
      // Reset state and a lone instruction read acked two cycles after mem_req rises.
      do_reset();
      stall_n = 0;
      for (int k = 0; k < 6; k++) begin
         if (k > 0) tick();
         if (k == 0) begin ic_re = 1; ic_addr = 32'h0000_0106; end
         mem_ack  = (k == 3);
         mem_dout = (k == 3) ? 32'h0000_0013 : 32'h0;
         if (k == 5) ic_re = 0;
         @(negedge clk);
         stall_n += int'(stall);
         if (k == 0) begin
            chk("rst_mem_req", 32'(mem_req), 0);
            chk("rst_mem_addr", mem_addr, 0);
            chk("rst_mem_we", 32'(mem_we), 0);
            chk("rst_mem_din", mem_din, 0);
            chk("rst_ic_dout", ic_dout, 0);
            chk("rst_dc_dout", dc_dout, 0);
            chk("rst_err", 32'(err), 0);
         end
         if (k == 1) begin
            chk("t1_mem_req", 32'(mem_req), 1);
            chk("t1_mem_addr", mem_addr, 32'h0000_0104);
            chk("t1_mem_we", 32'(mem_we), 0);
         end
         if (k == 4) begin
            chk("t1_ic_valid", 32'(ic_valid), 1);
            chk("t1_ic_dout", ic_dout, 32'h0000_0013);
         end
         if (k == 5) chk("t1_ic_valid_off", 32'(ic_valid), 0);
      end
      chk("t1_stall_cycles", 32'(stall_n), 4);

      // Simultaneous requests after reset: data first, instruction right after.
      do_reset();
      ic_re = 1; ic_addr = 32'h0000_0042; dc_re = 1; dc_addr = 32'h0000_0021;
      nd = 0; ni = 0; seq = 0; kd = 0; ki = 0; dv_prev = 0; iv_prev = 0;
      for (int k = 0; k < 16; k++) begin
         if (k > 0) tick();
         if (dv_prev) dc_re = 0;
         if (iv_prev) ic_re = 0;
         mem_ack  = mem_req;
         mem_dout = mem_addr ^ 32'hA5A5_0000;
         @(negedge clk);
         dv_prev = dc_valid;
         iv_prev = ic_valid;
         if (dc_valid) begin nd++; seq = seq * 10 + 2; kd = k; end
         if (ic_valid) begin ni++; seq = seq * 10 + 1; ki = k; end
      end
      chk("t2_order", 32'(seq), 21);
      chk("t2_dc_pulses", 32'(nd), 1);
      chk("t2_ic_pulses", 32'(ni), 1);
      chk("t2_gap", 32'(ki - kd), 3);
      chk("t2_dc_dout", dc_dout, 32'hA5A5_0020);
      chk("t2_ic_dout", ic_dout, 32'hA5A5_0040);

      // Byte store: forwarded enables and data, read data register untouched.
      dc_we = 4'b0100; dc_addr = 32'h0000_0010; dc_din = 32'h00AB_0000;
      nval = 0; seen = 0; dv_prev = 0;
      for (int k = 0; k < 8; k++) begin
         if (k > 0) tick();
         if (dv_prev) dc_we = 0;
         mem_ack = mem_req;
         @(negedge clk);
         dv_prev = dc_valid;
         if (mem_req && !seen) begin
            seen = 1;
            chk("t3_mem_we", 32'(mem_we), 32'h4);
            chk("t3_mem_din", mem_din, 32'h00AB_0000);
            chk("t3_mem_addr", mem_addr, 32'h0000_0010);
         end
         if (dc_valid) begin
            nval++;
            chk("t3_dc_dout", dc_dout, 32'hA5A5_0020);
         end
      end
      chk("t3_dc_pulses", 32'(nval), 1);

      // Backend never acks: watchdog aborts after TO issue cycles.
      tick();
      dc_re = 1; dc_addr = 32'h0000_0030; mem_ack = 0;
      nreq = 0; nval = 0; dv_prev = 0;
      for (int k = 0; k < 20; k++) begin
         if (k > 0) tick();
         if (dv_prev) dc_re = 0;
         @(negedge clk);
         dv_prev = dc_valid;
         nreq += int'(mem_req);
         if (dc_valid) begin
            nval++;
            chk("t4_dc_dout", dc_dout, 32'hDEADBEEF);
            chk("t4_err", 32'(err), 1);
         end
      end
      chk("t4_req_cycles", 32'(nreq), TO);
      chk("t4_dc_pulses", 32'(nval), 1);

      rand_phase(200, 40, 0);
      @(negedge clk);
      chk("t4_err_sticky", 32'(err), 1);

      // Sustained contention from reset: grants alternate starting with data.
      do_reset();
      @(negedge clk);
      chk("t5_err_cleared", 32'(err), 0);
      tick();
      ic_re = 1; ic_addr = 32'h0000_0100; dc_re = 1; dc_addr = 32'h0000_0200;
      seq = 0; ng = 0; seen = 0; dv_prev = 0; iv_prev = 0;
      for (int k = 0; k < 40; k++) begin
         if (k > 0) tick();
         if (ng >= 6 && dv_prev) dc_re = 0;
         if (ng >= 6 && iv_prev) ic_re = 0;
         mem_ack  = mem_req;
         mem_dout = $urandom;
         @(negedge clk);
         dv_prev = dc_valid;
         iv_prev = ic_valid;
         if (mem_req && !seen && ng < 6) begin
            ng++;
            seq = seq * 10 + ((mem_addr == 32'h0000_0200) ? 2 : 1);
         end
         seen = mem_req;
      end
      chk("t5_grant_order", 32'(seq), 212121);

      // Reset while an access is in flight, then a late ack.
      do_reset();
      dc_re = 1; dc_addr = 32'h0000_0044;
      tick();
      tick();
      @(negedge clk);
      chk("t6_in_issue", 32'(mem_req), 1);
      tick();
      rst = 1; dc_re = 0;
      tick();
      rst = 0; mem_ack = 1; mem_dout = 32'h0000_0077;
      @(negedge clk);
      chk("t6_mem_req", 32'(mem_req), 0);
      chk("t6_dc_valid", 32'(dc_valid), 0);
      chk("t6_err", 32'(err), 0);
      tick();
      mem_ack = 0; dc_re = 1;
      @(negedge clk);
      chk("t6_no_late_valid", 32'(dc_valid), 0);
      chk("t6_dc_dout", dc_dout, 0);
      tick();
      mem_ack = 1; mem_dout = 32'h0000_0099;
      @(negedge clk);
      chk("t6_regrant", 32'(mem_req), 1);
      tick();
      mem_ack = 0;
      tick();
      dc_re = 0;
      repeat (3) tick();

      rand_phase(3000, 25, 1);
      rand_phase(1000, 90, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
